sprite_blit_ctrl: RTL and testbench

Sequencer and arbiter for the single shared `sprite_buffer`. It accepts blit requests from `NUM_REQ` requesters and grants one at a time in round-robin order. For each granted request it sets the buffer orientation, streams 64 pixels from sprite ROM into the buffer, then streams the re-oriented pixels out as framebuffer writes at the requested screen position. It sits between the game-logic draw engines and the framebuffer write port.

---
 rtl/gfx_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 26 ++
 rtl/sprite_blit_ctrl.sv | 156 +++++++++++++++
 tb/tb_sprite_blit_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared sprite/orientation constants and blit FSM state type
package gfx_pkg;

  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] RIGHT = 2'd1;
  localparam logic [1:0] DOWN  = 2'd2;
  localparam logic [1:0] LEFT  = 2'd3;

  localparam int SPR_W   = 8;
  localparam int SPR_H   = 8;
  localparam int SPR_PIX = SPR_W * SPR_H;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    RSTART,
    DRAW,
    DONE
  } blit_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr
module rr_arbiter #(
  parameter int N = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [PTR_W-1:0] idx;

  // Scan from farthest to nearest so the nearest active requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_blit_ctrl.sv
// rtl/sprite_blit_ctrl.sv - arbitrates blit requests and sequences ROM -> sprite_buffer -> framebuffer
module sprite_blit_ctrl
  import gfx_pkg::*;
#(
  parameter int          NUM_REQ  = 2,
  parameter int          ADDR_W   = 12,
  parameter int          X_W      = 9,
  parameter int          Y_W      = 8,
  parameter int          SCREEN_W = 320,
  parameter int          SCREEN_H = 240,
  parameter logic [23:0] KEY_RGB  = 24'hFF00FF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_base,
  input  logic [NUM_REQ*2-1:0]      req_ori,
  input  logic [NUM_REQ*X_W-1:0]    req_x,
  input  logic [NUM_REQ*Y_W-1:0]    req_y,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [23:0]               rom_rgb,
  output logic                      buf_set_ori,
  output logic [1:0]                buf_ori,
  output logic                      buf_write,
  output logic                      buf_read,
  output logic [23:0]               buf_wrgb,
  input  logic [23:0]               buf_rrgb,
  output logic                      fb_we,
  output logic [X_W-1:0]            fb_x,
  output logic [Y_W-1:0]            fb_y,
  output logic [23:0]               fb_rgb
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int XW1 = X_W + 1;
  localparam int YW1 = Y_W + 1;
  localparam logic [X_W:0] LIM_X = XW1'(SCREEN_W);
  localparam logic [Y_W:0] LIM_Y = YW1'(SCREEN_H);

  blit_state_t        state;
  logic [5:0]         cnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  pick_base;
  logic [X_W-1:0]     pos_x;
  logic [Y_W-1:0]     pos_y;
  logic [X_W:0]       wide_x;
  logic [Y_W:0]       wide_y;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_gnt[k]) arb_idx = PTR_W'(k);
    end
    pick_base = req_base[int'(arb_idx)*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_ptr      <= '0;
      sel         <= '0;
      base        <= '0;
      pos_x       <= '0;
      pos_y       <= '0;
      gnt         <= '0;
      done        <= '0;
      rom_addr    <= '0;
      buf_set_ori <= 1'b0;
      buf_ori     <= 2'd0;
      buf_write   <= 1'b0;
      buf_read    <= 1'b0;
    end else begin
      buf_set_ori <= 1'b0;
      buf_write   <= 1'b0;
      buf_read    <= 1'b0;
      done        <= '0;
      case (state)
        IDLE: begin
          // The cycle showing done is skipped so the finished requester can drop req first.
          if (arb_gnt != '0 && done == '0) begin
            state       <= SETUP;
            gnt         <= arb_gnt;
            sel         <= arb_idx;
            base        <= pick_base;
            pos_x       <= req_x[int'(arb_idx)*X_W +: X_W];
            pos_y       <= req_y[int'(arb_idx)*Y_W +: Y_W];
            rom_addr    <= pick_base;
            buf_ori     <= req_ori[int'(arb_idx)*2 +: 2];
            buf_set_ori <= 1'b1;
            buf_write   <= 1'b1;
          end
        end
        SETUP: begin
          state    <= LOAD;
          cnt      <= '0;
          rom_addr <= base + ADDR_W'(1);
        end
        LOAD: begin
          cnt      <= cnt + 6'd1;
          rom_addr <= base + ADDR_W'(cnt) + ADDR_W'(2);
          if (cnt == 6'd63) begin
            state    <= RSTART;
            rom_addr <= '0;
            buf_read <= 1'b1;
          end
        end
        RSTART: begin
          state <= DRAW;
          cnt   <= '0;
        end
        DRAW: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd63) state <= DONE;
        end
        DONE: begin
          done   <= gnt;
          gnt    <= '0;
          rr_ptr <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel path is combinational so each buffer read lands on the framebuffer in the same cycle.
  always_comb begin
    wide_x   = {1'b0, pos_x} + XW1'(cnt[2:0]);
    wide_y   = {1'b0, pos_y} + YW1'(cnt[5:3]);
    buf_wrgb = (state == LOAD) ? rom_rgb : 24'h0;
    fb_we    = 1'b0;
    fb_x     = '0;
    fb_y     = '0;
    fb_rgb   = 24'h0;
    if (state == DRAW) begin
      fb_x   = wide_x[X_W-1:0];
      fb_y   = wide_y[Y_W-1:0];
      fb_rgb = buf_rrgb;
      fb_we  = (buf_rrgb != KEY_RGB) && (wide_x < LIM_X) && (wide_y < LIM_Y);
    end
  end

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// tb/tb_sprite_blit_ctrl.sv - scoreboard bench for sprite_blit_ctrl with ROM and sprite_buffer models
module tb_sprite_blit_ctrl;
  import gfx_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 12;
  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_base = '0;
  logic [NUM_REQ*2-1:0]      req_ori = '0;
  logic [NUM_REQ*X_W-1:0]    req_x = '0;
  logic [NUM_REQ*Y_W-1:0]    req_y = '0;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [ADDR_W-1:0]         rom_addr;
  logic [23:0]               rom_rgb = 24'h0;
  logic                      buf_set_ori, buf_write, buf_read;
  logic [1:0]                buf_ori;
  logic [23:0]               buf_wrgb;
  logic [23:0]               buf_rrgb;
  logic                      fb_we;
  logic [X_W-1:0]            fb_x;
  logic [Y_W-1:0]            fb_y;
  logic [23:0]               fb_rgb;

  typedef struct {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [23:0]    rgb;
  } wr_t;

  wr_t exp_q[$];
  int  exp_done_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  nwr = 0;
  int  done0_cnt = 0;

  logic [23:0] rom [0:4095];
  logic [23:0] bmem [0:63];
  logic [1:0]  bori = 2'd0;
  logic        wr_act = 1'b0;
  logic        rd_act = 1'b0;
  logic [5:0]  wr_i = 6'd0;
  logic [5:0]  rd_i = 6'd0;

  sprite_blit_ctrl #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .X_W(X_W), .Y_W(Y_W),
    .SCREEN_W(320), .SCREEN_H(240), .KEY_RGB(KEY)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_ori(req_ori),
    .req_x(req_x), .req_y(req_y), .gnt(gnt), .done(done), .rom_addr(rom_addr),
    .rom_rgb(rom_rgb), .buf_set_ori(buf_set_ori), .buf_ori(buf_ori),
    .buf_write(buf_write), .buf_read(buf_read), .buf_wrgb(buf_wrgb),
    .buf_rrgb(buf_rrgb), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_rgb(fb_rgb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_rgb <= rom[rom_addr];

  // Destination pixel k of an oriented sprite comes from source word src_idx(o, k).
  function automatic int src_idx(input logic [1:0] o, input int k);
    int r;
    int c;
    r = k / 8;
    c = k % 8;
    case (o)
      UP:      return r * 8 + c;
      RIGHT:   return (7 - c) * 8 + r;
      DOWN:    return (7 - r) * 8 + (7 - c);
      default: return c * 8 + (7 - r);
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      wr_act <= 1'b0;
      rd_act <= 1'b0;
      bori   <= 2'd0;
    end else begin
      if (buf_set_ori) bori <= buf_ori;
      if (buf_write) begin
        wr_act <= 1'b1;
        wr_i   <= 6'd0;
      end else if (wr_act) begin
        bmem[wr_i] <= buf_wrgb;
        wr_i       <= wr_i + 6'd1;
        if (wr_i == 6'd63) wr_act <= 1'b0;
      end
      if (buf_read) begin
        rd_act <= 1'b1;
        rd_i   <= 6'd0;
      end else if (rd_act) begin
        rd_i <= rd_i + 6'd1;
        if (rd_i == 6'd63) rd_act <= 1'b0;
      end
    end
  end

  assign buf_rrgb = rd_act ? bmem[src_idx(bori, int'(rd_i))] : 24'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fb_we) begin
      nwr++;
      if (exp_q.size() == 0) begin
        chk("fb_unexpected", {fb_x, fb_y, fb_rgb}, 64'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("fb_pix", {fb_x, fb_y, fb_rgb}, {e.x, e.y, e.rgb});
      end
    end
    if (done != '0) begin
      if (done[0]) done0_cnt++;
      if (exp_done_q.size() == 0) begin
        chk("done_unexpected", done, 0);
      end else begin
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[exp_done_q.pop_front()] = 1'b1;
        chk("done_idx", done, oh);
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic fill_rom(input int base, input int mode);
    for (int k = 0; k < 64; k++) begin
      case (mode)
        0: rom[(base + k) & 12'hFFF] = 24'(k);
        1: rom[(base + k) & 12'hFFF] = 24'($urandom) & 24'hFEFEFE;
        default: rom[(base + k) & 12'hFFF] = (k < 8) ? KEY : 24'h010000 + 24'(k);
      endcase
    end
  endtask

  task automatic push_blit(input int base, input logic [1:0] ori, input int x, input int y);
    for (int k = 0; k < 64; k++) begin
      int wx;
      int wy;
      logic [23:0] px;
      wr_t e;
      px = rom[(base + src_idx(ori, k)) & 12'hFFF];
      wx = x + (k % 8);
      wy = y + (k / 8);
      if (px != KEY && wx < 320 && wy < 240) begin
        e.x   = X_W'(wx);
        e.y   = Y_W'(wy);
        e.rgb = px;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic set_req(input int idx, input int base, input logic [1:0] ori,
                         input int x, input int y);
    req_base[idx*ADDR_W +: ADDR_W] = ADDR_W'(base);
    req_ori[idx*2 +: 2]            = ori;
    req_x[idx*X_W +: X_W]          = X_W'(x);
    req_y[idx*Y_W +: Y_W]          = Y_W'(y);
  endtask

  task automatic start_blit(input int idx, input int base, input logic [1:0] ori,
                            input int x, input int y, output int t0);
    logic [NUM_REQ-1:0] oh;
    set_req(idx, base, ori, x, y);
    push_blit(base, ori, x, y);
    exp_done_q.push_back(idx);
    @(posedge clk);
    #1;
    req[idx] = 1'b1;
    t0 = cyc;
    wait_cyc(t0 + 1);
    oh = '0;
    oh[idx] = 1'b1;
    chk("setup", {gnt, buf_set_ori, buf_write, buf_read, buf_ori, rom_addr},
        {oh, 1'b1, 1'b1, 1'b0, ori, ADDR_W'(base)});
  endtask

  task automatic finish_blit(input int idx, input int t0);
    while (done == '0 && cyc < t0 + 400) @(negedge clk);
    chk("done_lat", cyc - t0, 132);
    @(posedge clk);
    #1;
    req[idx] = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {gnt, done, rom_addr, buf_set_ori, buf_ori, buf_write, buf_read, fb_we}, 0);
    chk({tag, "_rgb"}, {buf_wrgb, fb_rgb}, 0);
    chk({tag, "_pos"}, {fb_x, fb_y}, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int n0;
    int d0;
    for (int a = 0; a < 4096; a++) rom[a] = 24'h0;
    do_reset();

    // Single UP blit, ROM word k = k
    fill_rom('h100, 0);
    n0 = nwr;
    start_blit(0, 'h100, UP, 10, 20, t0);
    finish_blit(0, t0);
    chk("up_writes", nwr - n0, 64);

    // RIGHT orientation of the same sprite
    n0 = nwr;
    start_blit(0, 'h100, RIGHT, 10, 20, t0);
    finish_blit(0, t0);
    chk("right_writes", nwr - n0, 64);

    // Transparent row 0 plus right/bottom clipping
    fill_rom('h300, 2);
    n0 = nwr;
    start_blit(0, 'h300, UP, 316, 236, t0);
    finish_blit(0, t0);
    chk("clip_writes", nwr - n0, 12);

    // Both requesters held: strict alternation from rr_ptr = 0
    do_reset();
    fill_rom('h400, 1);
    fill_rom('h500, 1);
    set_req(0, 'h400, DOWN, 0, 0);
    set_req(1, 'h500, LEFT, 100, 50);
    for (int b = 0; b < 4; b++) begin
      if (b % 2 == 0) push_blit('h400, DOWN, 0, 0);
      else            push_blit('h500, LEFT, 100, 50);
      exp_done_q.push_back(b % 2);
    end
    n0 = nwr;
    @(posedge clk);
    #1;
    req = 2'b11;
    t0 = cyc;
    for (int b = 0; b < 4; b++) begin
      wait_cyc(t0 + 1 + 133 * b);
      chk("rr_gnt", gnt, (b % 2 == 0) ? 2'b01 : 2'b10);
    end
    wait_cyc(t0 + 531);
    chk("rr_last_done", done, 2'b10);
    @(posedge clk);
    #1;
    req = '0;
    chk("rr_writes", nwr - n0, 256);

    // Reset during LOAD, then a fresh blit from requester 1
    do_reset();
    fill_rom('h200, 1);
    d0 = done0_cnt;
    start_blit(0, 'h200, UP, 50, 60, t0);
    wait_cyc(t0 + 32);
    rst = 1'b1;
    req = '0;
    wait_cyc(t0 + 33);
    chk_zero("rst_mid");
    exp_q.delete();
    exp_done_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill_rom('h600, 1);
    n0 = nwr;
    start_blit(1, 'h600, DOWN, 200, 100, t0);
    finish_blit(1, t0);
    chk("rst_writes", nwr - n0, 64);
    chk("rst_no_done0", done0_cnt - d0, 0);

    // ROM address wrap at the top of the address space
    fill_rom(4086, 1);
    n0 = nwr;
    start_blit(0, 4086, LEFT, 30, 40, t0);
    wait_cyc(t0 + 10);
    chk("wrap_pre", rom_addr, 4095);
    wait_cyc(t0 + 11);
    chk("wrap_zero", rom_addr, 0);
    finish_blit(0, t0);
    chk("wrap_writes", nwr - n0, 64);

    repeat (4) @(posedge clk);
    chk("exp_left", exp_q.size(), 0);
    chk("done_left", exp_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
